// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key/operand outputs of keypad_scanner.
// The master side is the scanner; the slave side is the keypad and its consumer.
interface keypad_scanner_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       row;
    logic [3:0]       col;
    logic             clear;
    logic [3:0]       key_code;
    logic             key_valid;
    logic [WIDTH-1:0] value;

    modport master (
        input  row, clear,
        output col, key_code, key_valid, value
    );

    modport slave (
        output row, clear,
        input  col, key_code, key_valid, value
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, hex key code strobe and nibble operand register.
// Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 6250,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int WIDTH          = 16,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
) (
    input logic              clk,
    input logic              rst,
    keypad_scanner_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_SCANS - 1);

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || WIDTH < 4 || (WIDTH % 4) != 0 ||
            REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
            $error("keypad_scanner: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [1:0]       col_idx;
    logic [1:0]       cand_row;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    rcnt;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic [WIDTH-1:0] value_r;
    logic             any_low;
    logic [1:0]       low_row;

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
`endif

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: map_key = 4'h1;  4'h1: map_key = 4'h2;  4'h2: map_key = 4'h3;  4'h3: map_key = 4'hA;
            4'h4: map_key = 4'h4;  4'h5: map_key = 4'h5;  4'h6: map_key = 4'h6;  4'h7: map_key = 4'hB;
            4'h8: map_key = 4'h7;  4'h9: map_key = 4'h8;  4'hA: map_key = 4'h9;  4'hB: map_key = 4'hC;
            4'hC: map_key = 4'h0;  4'hD: map_key = 4'hF;  4'hE: map_key = 4'hE;  default: map_key = 4'hD;
        endcase
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    // Lowest-index low row wins when several rows of one column are pressed.
    always_comb begin
        any_low = (row_s != 4'hF);
        casez (row_s)
            4'b???0: low_row = 2'd0;
            4'b??01: low_row = 2'd1;
            4'b?011: low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            row_meta <= kp.row;
            row_s    <= row_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            col_idx     <= '0;
            cand_row    <= '0;
            cnt         <= '0;
            rcnt        <= '0;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            key_valid_r <= 1'b0;
`ifdef KEY_REPEAT_EN
            if (state != HELD) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end
`endif
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (!any_low) begin
                            col_idx <= col_idx + 1'b1;
                        end else begin
                            cand_row <= low_row;
                            // A single required scan accepts on the detecting tick itself.
                            if (DEBOUNCE_SCANS == 1) begin
                                key_valid_r <= 1'b1;
                                key_code_r  <= map_key(low_row, col_idx);
                                rcnt        <= '0;
                                state       <= HELD;
                            end else begin
                                cnt   <= CW'(1);
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!row_s[cand_row]) begin
                            if (cnt == DB_LAST) begin
                                key_valid_r <= 1'b1;
                                key_code_r  <= map_key(cand_row, col_idx);
                                rcnt        <= '0;
                                state       <= HELD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt     <= '0;
                            col_idx <= col_idx + 1'b1;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (&row_s) begin
                            if (rcnt == DB_LAST) begin
                                rcnt    <= '0;
                                col_idx <= col_idx + 1'b1;
                                state   <= SCAN;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end else begin
                            rcnt <= '0;
                        end
`ifdef KEY_REPEAT_EN
                        if (!row_s[cand_row]) begin
                            if (rep_cnt == (rep_first ? RD_LAST : RR_LAST)) begin
                                key_valid_r <= 1'b1;
                                rep_cnt     <= '0;
                                rep_first   <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end else begin
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
                        end
`endif
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    // Shift keys in on the strobe cycle; clear overrides a coincident shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
        end else if (kp.clear) begin
            value_r <= '0;
        end else if (key_valid_r) begin
            value_r <= (value_r << 4) | WIDTH'(key_code_r);
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx);
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.value     = value_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives the rows from the strobed
// column, and expected codes/operand values come from the key table and a nibble-shift model.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 4;
    localparam int WIDTH          = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_scanner_if #(.WIDTH(WIDTH)) kp ();

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .WIDTH         (WIDTH),
        .REPEAT_DELAY  (64),
        .REPEAT_RATE   (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp.master)
    );

    always #5 clk = ~clk;

    // Key table indexed by row*4 + column.
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

    logic [15:0]      down = '0;
    logic             bounce_hi = 1'b0;
    logic [WIDTH-1:0] model = '0;
    int               checks = 0;
    int               errors = 0;
    int               vcount = 0;
    logic [3:0]       last_code = '0;

    // Pressed switches short their row to the currently strobed column.
    always_comb begin
        kp.row = 4'hF;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                if (down[r*4+c] && !kp.col[c] && !bounce_hi) kp.row[r] = 1'b0;
    end

    always @(negedge clk) begin
        checks++;
        assert ($countones(~kp.col) == 1) else begin
            errors++;
            $error("FAIL col_onehot: observed %b expected exactly one low bit", kp.col);
        end
        if (!rst && kp.key_valid) begin
            vcount++;
            last_code = kp.key_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] col_pat(input int unsigned c);
        logic [3:0] p;
        p = 4'b1111;
        p[c % 4] = 1'b0;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic press_wait(input logic [15:0] mask, output bit ok, output int lat);
        down = mask;
        ok   = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (kp.key_valid) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_settle(input logic [3:0] held, output int cyc);
        down = '0;
        cyc  = 0;
        while (kp.col === held && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic enter_key(input int unsigned idx, input logic [3:0] extra_code_check);
        int         n0, lat, cyc;
        bit         ok;
        logic [15:0] m;
        n0 = vcount;
        m = '0;
        m[idx] = 1'b1;
        press_wait(m, ok, lat);
        check("valid_timeout", ok, 1);
        check("key_code", kp.key_code, keymap[idx]);
        check("key_code_tbl", kp.key_code, extra_code_check);
        model = (model << 4) | WIDTH'(keymap[idx]);
        @(negedge clk);
        check("value", kp.value, model);
        release_settle(col_pat(idx % 4), cyc);
        check("release_timeout", cyc < 200, 1);
        check("one_valid", vcount, n0 + 1);
    endtask

    initial begin
        int          n0, lat, cyc;
        bit          ok;
        logic [3:0]  c0;
        logic [WIDTH-1:0] v0;
        logic [15:0] m;
        int unsigned ridx;

        kp.clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", kp.col, 4'b1110);
        check("rst_value", kp.value, 0);
        check("rst_valid", kp.key_valid, 0);
        check("rst_code", kp.key_code, 0);

        // Column walks one step every SCAN_DIV cycles from release of reset.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan_col", kp.col, col_pat((k / SCAN_DIV) % 4));
        end

        // Single press of key 6 (row 1, column 2) with hold and release timing.
        n0 = vcount;
        m = '0;
        m[6] = 1'b1;
        press_wait(m, ok, lat);
        check("p6_timeout", ok, 1);
        check("p6_code", kp.key_code, 4'h6);
        model = (model << 4) | WIDTH'(keymap[6]);
        @(negedge clk);
        check("p6_value", kp.value, 16'h0006);
        repeat (40) @(negedge clk);
        check("p6_col_held", kp.col, 4'b1011);
        check("p6_no_repeat", vcount, n0 + 1);
        release_settle(4'b1011, cyc);
        check("p6_release_timeout", cyc < 200, 1);
        check("p6_next_col", kp.col, 4'b0111);
        check("p6_release_time", (cyc >= 14) && (cyc <= 19), 1);

        // Two rows low in column 0: the lower row index (key 4) wins over key 0.
        n0 = vcount;
        m = '0;
        m[4]  = 1'b1;
        m[12] = 1'b1;
        press_wait(m, ok, lat);
        check("multi_timeout", ok, 1);
        check("multi_code", kp.key_code, keymap[4]);
        model = (model << 4) | WIDTH'(keymap[4]);
        @(negedge clk);
        check("multi_value", kp.value, model);
        release_settle(4'b1110, cyc);
        check("multi_count", vcount, n0 + 1);

        // Bounce: contact alternates every tick, must never be accepted.
        n0 = vcount;
        v0 = model;
        down = '0;
        down[9] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bounce_hi = i[0];
            repeat (SCAN_DIV) @(negedge clk);
        end
        down = '0;
        bounce_hi = 1'b0;
        check("bounce_no_valid", vcount, n0);
        check("bounce_value", kp.value, v0);
        c0 = kp.col;
        cyc = 0;
        while (kp.col === c0 && cyc < 3 * SCAN_DIV) begin
            @(negedge clk);
            cyc++;
        end
        check("bounce_scan_resumes", kp.col !== c0, 1);

        // Operand entry: 1, 2, 3, A, F after a clear.
        kp.clear = 1'b1;
        @(negedge clk);
        kp.clear = 1'b0;
        model = '0;
        check("clear_value", kp.value, 0);
        enter_key(0, 4'h1);
        check("entry_0001", kp.value, 16'h0001);
        enter_key(1, 4'h2);
        enter_key(2, 4'h3);
        enter_key(3, 4'hA);
        check("entry_123A", kp.value, 16'h123A);
        enter_key(13, 4'hF);
        check("entry_23AF", kp.value, 16'h23AF);

        // Randomized keys against the table/shift model.
        for (int i = 0; i < 6; i++) begin
            ridx = $urandom_range(0, 15);
            enter_key(ridx, keymap[ridx]);
        end

        // clear coincident with key 7's strobe: clear wins, strobe still reports the key.
        n0 = vcount;
        m = '0;
        m[8] = 1'b1;
        press_wait(m, ok, lat);
        check("clr7_timeout", ok, 1);
        check("clr7_valid", kp.key_valid, 1);
        check("clr7_code", kp.key_code, 4'h7);
        kp.clear = 1'b1;
        @(negedge clk);
        kp.clear = 1'b0;
        model = '0;
        check("clr7_value", kp.value, 0);
        release_settle(4'b1110, cyc);
        check("clr7_count", vcount, n0 + 1);

        // Reset during debounce of key 5; the held key is re-detected after reset.
        cyc = 0;
        while (kp.col !== 4'b1110 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n0 = vcount;
        down = '0;
        down[5] = 1'b1;
        cyc = 0;
        while (kp.col !== 4'b1101 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rstdb_reach_col1", kp.col, 4'b1101);
        repeat (9) @(negedge clk);
        check("rstdb_not_yet", vcount, n0);
        rst = 1'b1;
        @(negedge clk);
        check("rstdb_col", kp.col, 4'b1110);
        check("rstdb_valid", kp.key_valid, 0);
        check("rstdb_code", kp.key_code, 0);
        check("rstdb_value", kp.value, 0);
        model = '0;
        rst = 1'b0;
        m = down;
        press_wait(m, ok, lat);
        check("rstdb_timeout", ok, 1);
        check("rstdb_latency", lat, 20);
        check("rstdb_key", kp.key_code, 4'h5);
        model = (model << 4) | WIDTH'(keymap[5]);
        @(negedge clk);
        check("rstdb_value_after", kp.value, 16'h0005);
        release_settle(4'b1101, cyc);
        check("rstdb_once", vcount, n0 + 1);
        check("last_code", last_code, 4'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
